// File: rtl/spio_hss_multiplexer_param_dispatcher.sv
// -----------------------------------------------------------------------------
// spio_hss_multiplexer_param_dispatcher
//
// Receive-side packet dispatcher for the HSS multiplexer link. Packets arriving
// from the frame disassembler are queued in one FIFO per virtual channel. The
// FIFOs drive the per-channel output handshakes and the local channel flow
// control. Each end-of-frame is checked against the expected sequence number,
// the expected colour and the overflow flag. The result is turned into an ack
// or nack request for the frame transmitter.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   ipkt_data/vld/colour      incoming packets, one slot per channel, no backpressure
//   frm_colour/seq/vld        end-of-frame report
//   ooc_colour/vld            remote out-of-credit report
//   opkt_data/vld/rdy         per-channel FIFO head with valid/ready handshake
//   cfc_loc                   per-channel "stop sending" flow control
//   ack_type/colour/seq/rts   pending ack(0)/nack(1) request, held until ack_rdy
//   ack_rdy                   transmitter accepts the pending request
//   reg_rfrm/busy/lnak/lack   wrapping statistics counters
// -----------------------------------------------------------------------------
module spio_hss_multiplexer_param_dispatcher #(
    parameter int NUM_CHANS  = 8,
    parameter int PKT_BITS   = 72,
    parameter int FIFO_DEPTH = 4,
    parameter int CFC_MARGIN = 2,
    parameter int SEQ_BITS   = 7,
    parameter int CNT_BITS   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CHANS*PKT_BITS-1:0] ipkt_data,
    input  logic [NUM_CHANS-1:0]          ipkt_vld,
    input  logic                          ipkt_colour,
    input  logic                          frm_colour,
    input  logic [SEQ_BITS-1:0]           frm_seq,
    input  logic                          frm_vld,
    input  logic                          ooc_colour,
    input  logic                          ooc_vld,
    output logic [NUM_CHANS*PKT_BITS-1:0] opkt_data,
    output logic [NUM_CHANS-1:0]          opkt_vld,
    input  logic [NUM_CHANS-1:0]          opkt_rdy,
    output logic [NUM_CHANS-1:0]          cfc_loc,
    output logic                          ack_type,
    output logic                          ack_colour,
    output logic [SEQ_BITS-1:0]           ack_seq,
    output logic                          ack_rts,
    input  logic                          ack_rdy,
    output logic [CNT_BITS-1:0]           reg_rfrm,
    output logic [CNT_BITS-1:0]           reg_busy,
    output logic [CNT_BITS-1:0]           reg_lnak,
    output logic [CNT_BITS-1:0]           reg_lack
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CFC_THR  = CW'(FIFO_DEPTH - CFC_MARGIN);

    // Per-channel FIFO state
    logic [PKT_BITS-1:0] mem_q    [NUM_CHANS][FIFO_DEPTH];
    logic [AW-1:0]       rd_ptr_q [NUM_CHANS];
    logic [AW-1:0]       wr_ptr_q [NUM_CHANS];
    logic [CW-1:0]       cnt_q    [NUM_CHANS];
    logic [CW-1:0]       cnt_d    [NUM_CHANS];
    logic [NUM_CHANS-1:0] cfc_q;
    logic [NUM_CHANS-1:0] pop, push, drop;

    // Frame-check state
    logic [SEQ_BITS-1:0] exp_seq_q, exp_seq_d;
    logic                exp_colour_q, exp_colour_d;
    logic                ovf_q, ovf_d;
    logic                lnack_colour_q, lnack_colour_d;
    logic [SEQ_BITS-1:0] lnack_seq_q, lnack_seq_d;
    logic                frm_ok;

    // Request slot
    logic                rts_q, rts_d;
    logic                type_q, type_d;
    logic                colour_q, colour_d;
    logic [SEQ_BITS-1:0] seq_q, seq_d;
    logic                post_vld, post_type, post_colour;
    logic [SEQ_BITS-1:0] post_seq;
    logic                taken, load;

    logic [CNT_BITS-1:0] rfrm_q, busy_q, lnak_q, lack_q;

    // ---------------------------------------------------------------------
    // FIFO push/pop decisions
    // ---------------------------------------------------------------------
    always_comb begin
        pop       = '0;
        push      = '0;
        drop      = '0;
        opkt_vld  = '0;
        opkt_data = '0;
        for (int c = 0; c < NUM_CHANS; c++) begin
            cnt_d[c] = cnt_q[c];
        end
        for (int c = 0; c < NUM_CHANS; c++) begin
            opkt_vld[c] = (cnt_q[c] != '0);
            opkt_data[c*PKT_BITS +: PKT_BITS] = mem_q[c][rd_ptr_q[c]];
            pop[c] = opkt_vld[c] & opkt_rdy[c];
            // Packets of a stale colour vanish without touching ovf; a full
            // FIFO still accepts if its head leaves in the same cycle.
            if (ipkt_vld[c] && (ipkt_colour == exp_colour_q)) begin
                if ((cnt_q[c] != FULL_CNT) || pop[c]) begin
                    push[c] = 1'b1;
                end else begin
                    drop[c] = 1'b1;
                end
            end
            cnt_d[c] = cnt_q[c] + CW'(push[c]) - CW'(pop[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfc_q <= '0;
            for (int c = 0; c < NUM_CHANS; c++) begin
                rd_ptr_q[c] <= '0;
                wr_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CHANS; c++) begin
                cnt_q[c] <= cnt_d[c];
                cfc_q[c] <= (cnt_d[c] >= CFC_THR);
                if (pop[c])  rd_ptr_q[c] <= rd_ptr_q[c] + AW'(1);
                if (push[c]) wr_ptr_q[c] <= wr_ptr_q[c] + AW'(1);
            end
        end
    end

    // Storage carries no reset; emptiness is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CHANS; c++) begin
            if (push[c]) mem_q[c][wr_ptr_q[c]] <= ipkt_data[c*PKT_BITS +: PKT_BITS];
        end
    end

    // ---------------------------------------------------------------------
    // Frame check and request generation
    // ---------------------------------------------------------------------
    always_comb begin
        exp_seq_d      = exp_seq_q;
        exp_colour_d   = exp_colour_q;
        lnack_colour_d = lnack_colour_q;
        lnack_seq_d    = lnack_seq_q;
        post_vld       = 1'b0;
        post_type      = 1'b0;
        post_colour    = 1'b0;
        post_seq       = '0;
        frm_ok = frm_vld && (frm_colour == exp_colour_q) && (frm_seq == exp_seq_q) && !ovf_q;

        // A frame report closes the current overflow window; a drop in the
        // same cycle belongs to the following frame.
        ovf_d = frm_vld ? (|drop) : (ovf_q | (|drop));

        // End-of-frame takes precedence over an out-of-credit report that
        // arrives in the same cycle.
        if (frm_ok) begin
            exp_seq_d   = exp_seq_q + SEQ_BITS'(1);
            post_vld    = 1'b1;
            post_type   = 1'b0;
            post_colour = exp_colour_q;
            post_seq    = frm_seq;
        end else if (frm_vld) begin
            exp_colour_d   = ~exp_colour_q;
            post_vld       = 1'b1;
            post_type      = 1'b1;
            post_colour    = ~exp_colour_q;
            post_seq       = exp_seq_q;
            lnack_colour_d = ~exp_colour_q;
            lnack_seq_d    = exp_seq_q;
        end else if (ooc_vld) begin
            post_vld = 1'b1;
            if (ooc_colour == exp_colour_q) begin
                post_type   = 1'b0;
                post_colour = exp_colour_q;
                post_seq    = exp_seq_q - SEQ_BITS'(1);
            end else begin
                post_type   = 1'b1;
                post_colour = lnack_colour_q;
                post_seq    = lnack_seq_q;
            end
        end

        // Single-entry slot: a pending nack only yields to another nack.
        taken    = rts_q & ack_rdy;
        load     = post_vld & (~rts_q | taken | ~type_q | post_type);
        rts_d    = load | (rts_q & ~taken);
        type_d   = load ? post_type   : type_q;
        colour_d = load ? post_colour : colour_q;
        seq_d    = load ? post_seq    : seq_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_seq_q      <= '0;
            exp_colour_q   <= 1'b0;
            ovf_q          <= 1'b0;
            lnack_colour_q <= 1'b0;
            lnack_seq_q    <= '0;
            rts_q          <= 1'b0;
            type_q         <= 1'b0;
            colour_q       <= 1'b0;
            seq_q          <= '0;
            rfrm_q         <= '0;
            busy_q         <= '0;
            lnak_q         <= '0;
            lack_q         <= '0;
        end else begin
            exp_seq_q      <= exp_seq_d;
            exp_colour_q   <= exp_colour_d;
            ovf_q          <= ovf_d;
            lnack_colour_q <= lnack_colour_d;
            lnack_seq_q    <= lnack_seq_d;
            rts_q          <= rts_d;
            type_q         <= type_d;
            colour_q       <= colour_d;
            seq_q          <= seq_d;
            if (frm_ok)                      rfrm_q <= rfrm_q + CNT_BITS'(1);
            if (|(opkt_vld & ~opkt_rdy))     busy_q <= busy_q + CNT_BITS'(1);
            if (taken && type_q)             lnak_q <= lnak_q + CNT_BITS'(1);
            if (taken && !type_q)            lack_q <= lack_q + CNT_BITS'(1);
        end
    end

    assign cfc_loc    = cfc_q;
    assign ack_rts    = rts_q;
    assign ack_type   = type_q;
    assign ack_colour = colour_q;
    assign ack_seq    = seq_q;
    assign reg_rfrm   = rfrm_q;
    assign reg_busy   = busy_q;
    assign reg_lnak   = lnak_q;
    assign reg_lack   = lack_q;

endmodule

// File: tb/tb_spio_hss_multiplexer_param_dispatcher.sv
// Randomized bench for the HSS receive dispatcher, compared every cycle
// against a queue-based reference model of the dispatch rules.
module tb_spio_hss_multiplexer_param_dispatcher;

    localparam int NC    = 8;
    localparam int PB    = 72;
    localparam int DEPTH = 4;
    localparam int MARG  = 2;
    localparam int SB    = 7;
    localparam int CB    = 32;

    typedef logic [PB-1:0] pkt_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC*PB-1:0]  ipkt_data;
    logic [NC-1:0]     ipkt_vld;
    logic              ipkt_colour;
    logic              frm_colour;
    logic [SB-1:0]     frm_seq;
    logic              frm_vld;
    logic              ooc_colour;
    logic              ooc_vld;
    logic [NC*PB-1:0]  opkt_data;
    logic [NC-1:0]     opkt_vld;
    logic [NC-1:0]     opkt_rdy;
    logic [NC-1:0]     cfc_loc;
    logic              ack_type;
    logic              ack_colour;
    logic [SB-1:0]     ack_seq;
    logic              ack_rts;
    logic              ack_rdy;
    logic [CB-1:0]     reg_rfrm;
    logic [CB-1:0]     reg_busy;
    logic [CB-1:0]     reg_lnak;
    logic [CB-1:0]     reg_lack;

    spio_hss_multiplexer_param_dispatcher #(
        .NUM_CHANS(NC), .PKT_BITS(PB), .FIFO_DEPTH(DEPTH),
        .CFC_MARGIN(MARG), .SEQ_BITS(SB), .CNT_BITS(CB)
    ) dut (
        .clk(clk), .rst(rst),
        .ipkt_data(ipkt_data), .ipkt_vld(ipkt_vld), .ipkt_colour(ipkt_colour),
        .frm_colour(frm_colour), .frm_seq(frm_seq), .frm_vld(frm_vld),
        .ooc_colour(ooc_colour), .ooc_vld(ooc_vld),
        .opkt_data(opkt_data), .opkt_vld(opkt_vld), .opkt_rdy(opkt_rdy),
        .cfc_loc(cfc_loc),
        .ack_type(ack_type), .ack_colour(ack_colour), .ack_seq(ack_seq),
        .ack_rts(ack_rts), .ack_rdy(ack_rdy),
        .reg_rfrm(reg_rfrm), .reg_busy(reg_busy), .reg_lnak(reg_lnak), .reg_lack(reg_lack)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Wrap detection for the sequence-number boundary
    int n_wraps = 0;

    // ---------------- reference model state ----------------
    pkt_t          mq [NC][$];
    logic [SB-1:0] m_exp_seq;
    logic          m_exp_col;
    logic          m_ovf;
    logic          m_rts, m_type, m_col;
    logic [SB-1:0] m_seq;
    logic          m_ln_col;
    logic [SB-1:0] m_ln_seq;
    logic [NC-1:0] m_cfc;
    logic [CB-1:0] m_rfrm, m_busy, m_lnak, m_lack;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) mq[c].delete();
        m_exp_seq = '0; m_exp_col = 1'b0; m_ovf = 1'b0;
        m_rts = 1'b0; m_type = 1'b0; m_col = 1'b0; m_seq = '0;
        m_ln_col = 1'b0; m_ln_seq = '0; m_cfc = '0;
        m_rfrm = '0; m_busy = '0; m_lnak = '0; m_lack = '0;
    endtask

    // One clock of the dispatch rules, applied to the inputs currently driven.
    task automatic model_step();
        logic          dropped;
        logic          any_busy;
        logic          taken;
        logic          have_post;
        logic          p_type, p_col;
        logic [SB-1:0] p_seq;
        logic          old_col;
        logic [SB-1:0] old_seq;
        if (rst) begin
            model_reset();
        end else begin
            dropped   = 1'b0;
            any_busy  = 1'b0;
            have_post = 1'b0;
            p_type = 1'b0; p_col = 1'b0; p_seq = '0;
            old_col = m_exp_col;
            old_seq = m_exp_seq;
            taken = m_rts && ack_rdy;

            for (int c = 0; c < NC; c++) begin
                if (mq[c].size() > 0 && !opkt_rdy[c]) any_busy = 1'b1;
                if (mq[c].size() > 0 && opkt_rdy[c]) void'(mq[c].pop_front());
                if (ipkt_vld[c] && ipkt_colour == old_col) begin
                    if (mq[c].size() < DEPTH) mq[c].push_back(ipkt_data[c*PB +: PB]);
                    else dropped = 1'b1;
                end
                m_cfc[c] = (mq[c].size() >= DEPTH - MARG);
            end

            if (frm_vld) begin
                have_post = 1'b1;
                if (frm_colour == old_col && frm_seq == old_seq && !m_ovf) begin
                    p_type = 1'b0; p_col = old_col; p_seq = frm_seq;
                    m_exp_seq = old_seq + 7'd1;
                    if (old_seq == 7'd127) n_wraps++;
                    m_rfrm = m_rfrm + 32'd1;
                end else begin
                    p_type = 1'b1; p_col = !old_col; p_seq = old_seq;
                    m_ln_col = !old_col; m_ln_seq = old_seq;
                    m_exp_col = !old_col;
                end
                m_ovf = dropped;
            end else begin
                m_ovf = m_ovf | dropped;
                if (ooc_vld) begin
                    have_post = 1'b1;
                    if (ooc_colour == old_col) begin
                        p_type = 1'b0; p_col = old_col; p_seq = old_seq - 7'd1;
                    end else begin
                        p_type = 1'b1; p_col = m_ln_col; p_seq = m_ln_seq;
                    end
                end
            end

            if (any_busy) m_busy = m_busy + 32'd1;
            if (taken) begin
                if (m_type) m_lnak = m_lnak + 32'd1;
                else        m_lack = m_lack + 32'd1;
            end

            if (taken) m_rts = 1'b0;
            if (have_post) begin
                // an occupied slot holding a nack refuses a new ack
                if (!(m_rts && m_type && !p_type)) begin
                    m_rts = 1'b1; m_type = p_type; m_col = p_col; m_seq = p_seq;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < NC; c++) begin
            chk("opkt_vld", 128'(opkt_vld[c]), 128'(mq[c].size() > 0));
            if (mq[c].size() > 0)
                chk("opkt_data", 128'(opkt_data[c*PB +: PB]), 128'(mq[c][0]));
        end
        chk("cfc_loc",    128'(cfc_loc),    128'(m_cfc));
        chk("ack_rts",    128'(ack_rts),    128'(m_rts));
        chk("ack_type",   128'(ack_type),   128'(m_type));
        chk("ack_colour", 128'(ack_colour), 128'(m_col));
        chk("ack_seq",    128'(ack_seq),    128'(m_seq));
        chk("reg_rfrm",   128'(reg_rfrm),   128'(m_rfrm));
        chk("reg_busy",   128'(reg_busy),   128'(m_busy));
        chk("reg_lnak",   128'(reg_lnak),   128'(m_lnak));
        chk("reg_lack",   128'(reg_lack),   128'(m_lack));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        ipkt_data = '0; ipkt_vld = '0; ipkt_colour = 1'b0;
        frm_colour = 1'b0; frm_seq = '0; frm_vld = 1'b0;
        ooc_colour = 1'b0; ooc_vld = 1'b0;
        opkt_rdy = '1; ack_rdy = 1'b1;
    endtask

    // Random stimulus biased towards legal traffic so that acks, nacks,
    // overflows and stale-colour drops all occur.
    task automatic rand_inputs(input int p_pkt, input int p_rdy, input int p_ack, input int p_frm);
        for (int c = 0; c < NC; c++) begin
            ipkt_data[c*PB +: PB] = PB'({$urandom, $urandom, $urandom});
            ipkt_vld[c] = ($urandom_range(99) < p_pkt);
            opkt_rdy[c] = ($urandom_range(99) < p_rdy);
        end
        ipkt_colour = ($urandom_range(9) == 0) ? !m_exp_col : m_exp_col;
        ack_rdy     = ($urandom_range(99) < p_ack);
        frm_vld     = ($urandom_range(99) < p_frm);
        frm_colour  = ($urandom_range(9) == 0) ? !m_exp_col : m_exp_col;
        frm_seq     = ($urandom_range(9) < 8) ? m_exp_seq : SB'($urandom);
        ooc_vld     = !frm_vld && ($urandom_range(19) == 0);
        ooc_colour  = 1'($urandom);
    endtask

    initial begin
        model_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        idle_inputs();
        cycle();

        // Phase A: free-flowing consumers, prompt transmitter
        for (int i = 0; i < 1500; i++) begin rand_inputs(40, 90, 80, 15); cycle(); end
        // Phase B: slow consumers -> FIFO fill, flow control, overflow nacks
        for (int i = 0; i < 1500; i++) begin rand_inputs(50, 20, 70, 12); cycle(); end
        // Phase C: stalled transmitter -> request overwrite rules
        for (int i = 0; i < 1500; i++) begin rand_inputs(30, 80, 5, 20); cycle(); end

        // Phase D: clean frames only, enough to carry exp_seq past 127
        idle_inputs();
        for (int i = 0; i < 300; i++) begin
            frm_vld    = (i % 2 == 0);
            frm_colour = m_exp_col;
            frm_seq    = m_exp_seq;
            ack_rdy    = 1'(i % 3 != 0);
            cycle();
        end
        idle_inputs();
        cycle();
        chk("seq_wrap_seen", 128'(n_wraps > 0), 128'(1));

        // Reset in the middle of traffic, then resume
        for (int i = 0; i < 50; i++) begin rand_inputs(60, 30, 10, 15); cycle(); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        idle_inputs();
        cycle();
        for (int i = 0; i < 1000; i++) begin rand_inputs(45, 60, 50, 15); cycle(); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
